// File: rtl/aes_sbox_arbiter.sv
// Purpose: round-robin arbiter that shares one combinational 4-byte AES S-box among
//          key expansion (0), encipher lane A (1) and encipher lane B (2).
// Latency: a grant appears 1 cycle after a request raised in IDLE, and 0 cycles
//          while the owner keeps its request asserted.
// Backpressure: a requester holds reqN until it sees gntN. A requester that drops
//               reqN before it is granted is forgotten.
//
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   req0..req2              S-box access requests
//   sboxw0..sboxw2          word each requester wants substituted
//   gnt0..gnt2              new_sboxw is valid for that requester this cycle
//   sboxw                   word driven to the shared S-box (0 when not busy)
//   new_sboxw               S-box result, taken directly by the requesters
//   owner, busy             current owner index; arbiter is in GRANT
module aes_sbox_arbiter #(
  parameter int MAX_BURST = 4  // legal range 1..7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic [31:0] sboxw0,
  input  logic [31:0] sboxw1,
  input  logic [31:0] sboxw2,
  output logic        gnt0,
  output logic        gnt1,
  output logic        gnt2,
  output logic [31:0] sboxw,
  input  logic [31:0] new_sboxw,
  output logic [1:0]  owner,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [2:0] BURST_LAST = 3'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [1:0] owner_reg, owner_nxt;
  logic [1:0] last_reg, last_nxt;
  logic [2:0] burst_ctr, burst_nxt;
  logic [2:0] req_vec;
  logic [2:0] others;
  logic [3:0] req_pad;
  logic       owner_req;

  // The S-box result goes straight from the S-box to the requesters. The arbiter
  // only carries the port so that the datapath wiring stays in one place.
  logic unused_new_sboxw;
  assign unused_new_sboxw = ^new_sboxw;

  // Step to the next index in the order 0 -> 1 -> 2 -> 0.
  // Index 3 wraps to 0 through the 2-bit add.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Return the first set bit of r, searching from start in round-robin order.
  // The caller only uses the result when r is non-zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [2:0] r);
    logic [3:0] rp;
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    rp    = {1'b0, r};
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && rp[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = rr_next(idx);
    end
    return pick;
  endfunction

  assign req_vec   = {req2, req1, req0};
  assign req_pad   = {1'b0, req_vec};
  assign owner_req = req_pad[owner_reg];
  // Requests other than the owner's. An owner index of 3 shifts out and masks nothing.
  assign others    = req_vec & ~(3'b001 << owner_reg);

  assign busy  = (state == GRANT);
  assign owner = owner_reg;
  assign gnt0  = busy & (owner_reg == 2'd0) & req0;
  assign gnt1  = busy & (owner_reg == 2'd1) & req1;
  assign gnt2  = busy & (owner_reg == 2'd2) & req2;

  always_comb begin
    sboxw = 32'h0;
    if (busy) begin
      case (owner_reg)
        2'd0:    sboxw = sboxw0;
        2'd1:    sboxw = sboxw1;
        2'd2:    sboxw = sboxw2;
        default: sboxw = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_reg;
    last_nxt  = last_reg;
    burst_nxt = burst_ctr;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          state_nxt = GRANT;
          owner_nxt = rr_pick(rr_next(last_reg), req_vec);
          burst_nxt = 3'd0;
        end
      end
      GRANT: begin
        if (owner_reg == 2'd3) begin
          // This state cannot be reached in normal operation. Leave it safely.
          state_nxt = IDLE;
          owner_nxt = 2'd0;
          burst_nxt = 3'd0;
        end else if (owner_req) begin
          if (burst_ctr == BURST_LAST) begin
            if (|others) begin
              owner_nxt = rr_pick(rr_next(owner_reg), others);
              last_nxt  = owner_reg;
            end
            // With no other requester, the owner keeps streaming and the counter wraps.
            burst_nxt = 3'd0;
          end else begin
            burst_nxt = burst_ctr + 3'd1;
          end
        end else begin
          // The owner has released the S-box. Hand it over at the next edge,
          // or go idle if nobody else is asking.
          last_nxt  = owner_reg;
          burst_nxt = 3'd0;
          if (|others) begin
            owner_nxt = rr_pick(rr_next(owner_reg), others);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_reg <= 2'd0;
      last_reg  <= 2'd2;  // requester 0 wins the first arbitration
      burst_ctr <= 3'd0;
    end else begin
      state     <= state_nxt;
      owner_reg <= owner_nxt;
      last_reg  <= last_nxt;
      burst_ctr <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Purpose: directed checks of aes_sbox_arbiter using a per-cycle vector table plus
//          hand-written multi-cycle sequences.
// Latency: inputs are driven 1 time unit after the rising edge and outputs are
//          sampled on the falling edge.
// Backpressure: the bench requesters hold their requests for fixed durations.
module tb_aes_sbox_arbiter;

  localparam logic [31:0] W0 = 32'hA0A1A2A3;
  localparam logic [31:0] W1 = 32'h00112233;
  localparam logic [31:0] W2 = 32'hC4C5C6C7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0;
  logic [31:0] sboxw0 = W0, sboxw1 = W1, sboxw2 = W2;
  logic        gnt0, gnt1, gnt2;
  logic [31:0] sboxw;
  logic [31:0] new_sboxw = 32'h0;
  logic [1:0]  owner;
  logic        busy;
  logic [2:0]  gnt_v;

  int errors = 0;
  int checks = 0;

  assign gnt_v = {gnt2, gnt1, gnt0};

  always #5 clk = ~clk;

  aes_sbox_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .req2(req2),
    .sboxw0(sboxw0), .sboxw1(sboxw1), .sboxw2(sboxw2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .sboxw(sboxw), .new_sboxw(new_sboxw),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic [31:0] sbox;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] r);
    {req2, req1, req0} = r;
  endtask

  // Leaves the bench 1 time unit after a rising edge, with reset released.
  task automatic do_reset();
    set_req(3'b000);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // A stuck simulation still reaches a FAIL line before stopping.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // One row per cycle: one requester alone, then an early release with a short
    // pulse on req2 that is never granted.
    tbl[0]  = '{3'b010, 3'b000, 1'b0, 2'd0, 32'h0};
    tbl[1]  = '{3'b010, 3'b010, 1'b1, 2'd1, W1};
    tbl[2]  = '{3'b010, 3'b010, 1'b1, 2'd1, W1};
    tbl[3]  = '{3'b010, 3'b010, 1'b1, 2'd1, W1};
    tbl[4]  = '{3'b010, 3'b010, 1'b1, 2'd1, W1};
    tbl[5]  = '{3'b000, 3'b000, 1'b1, 2'd1, W1};
    tbl[6]  = '{3'b000, 3'b000, 1'b0, 2'd1, 32'h0};
    tbl[7]  = '{3'b011, 3'b000, 1'b0, 2'd1, 32'h0};
    tbl[8]  = '{3'b111, 3'b001, 1'b1, 2'd0, W0};
    tbl[9]  = '{3'b011, 3'b001, 1'b1, 2'd0, W0};
    tbl[10] = '{3'b010, 3'b000, 1'b1, 2'd0, W0};
    tbl[11] = '{3'b010, 3'b010, 1'b1, 2'd1, W1};
    tbl[12] = '{3'b000, 3'b000, 1'b1, 2'd1, W1};
    tbl[13] = '{3'b000, 3'b000, 1'b0, 2'd1, 32'h0};

    // Outputs while reset is held.
    #2;
    chk("reset_gnt", {29'h0, gnt_v}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_sboxw", sboxw, 32'h0);
    chk("reset_owner", {30'h0, owner}, 32'h0);

    // Table-driven sequence.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_req(tbl[i].req);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), {29'h0, gnt_v}, {29'h0, tbl[i].gnt});
      chk($sformatf("tbl%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_owner", i), {30'h0, owner}, {30'h0, tbl[i].owner});
      chk($sformatf("tbl%0d_sboxw", i), sboxw, tbl[i].sbox);
      next_cycle();
    end

    // All three requesters rise together after reset. Expected owners are
    // 0, 1, 2, 0, with 4 grant cycles each.
    do_reset();
    set_req(3'b111);
    @(negedge clk);
    chk("all_first_gnt", {29'h0, gnt_v}, 32'h0);
    next_cycle();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("all_c%0d_gnt", k), {29'h0, gnt_v}, {29'h0, 3'b001 << ((k / 4) % 3)});
      next_cycle();
    end
    set_req(3'b000);

    // req2 alone for 10 grants. The burst counter wraps 3 -> 0 without a gap.
    do_reset();
    set_req(3'b100);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_c%0d_gnt2", k), {29'h0, gnt_v}, 32'h4);
      chk($sformatf("wrap_c%0d_ctr", k), {29'h0, dut.burst_ctr}, k % 4);
      next_cycle();
    end
    set_req(3'b000);
    @(negedge clk);
    chk("wrap_release_gnt", {29'h0, gnt_v}, 32'h0);
    next_cycle();

    // Reset in the middle of owner 1's burst, once burst_ctr has reached 2.
    do_reset();
    set_req(3'b010);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("mid_owner", {30'h0, owner}, 32'h1);
    chk("mid_ctr", {29'h0, dut.burst_ctr}, 32'h2);
    chk("mid_gnt", {29'h0, gnt_v}, 32'h2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {29'h0, gnt_v}, 32'h0);
    chk("mid_rst_sboxw", sboxw, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    set_req(3'b110);
    @(negedge clk);
    chk("post_rst_idle_gnt", {29'h0, gnt_v}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_owner", {30'h0, owner}, 32'h1);
    chk("post_rst_gnt", {29'h0, gnt_v}, 32'h2);
    chk("post_rst_sboxw", sboxw, W1);
    set_req(3'b000);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
